// File: rtl/tcdm_bank_adapter.sv
// Purpose: adapt a valid/ready TCDM slave port with an initiator tag to a 1-cycle single-port SRAM bank.
// Latency: requests reach the bank in the accept cycle; read data appears on in_resp_* one cycle later through a fall-through FIFO.
// Backpressure: in_req_ready_o comes from a registered credit count, so resp_ready stalls never drop bank data.
//
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   in_req_*                          request channel (valid/ready, address, tag, write enable, data, byte enables)
//   in_resp_*                         read response channel (valid/ready, tag, read data)
//   bank_*                            SRAM bank strobe, write enable, address, write data, byte enables, read data
module tcdm_bank_adapter #(
    parameter int AddrWidth    = 10,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int IniAddrWidth = 4,
    parameter int FifoDepth    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    in_req_valid_i,
    output logic                    in_req_ready_o,
    input  logic [AddrWidth-1:0]    in_req_tgt_addr_i,
    input  logic [IniAddrWidth-1:0] in_req_ini_addr_i,
    input  logic                    in_req_wen_i,
    input  logic [DataWidth-1:0]    in_req_wdata_i,
    input  logic [BeWidth-1:0]      in_req_be_i,

    output logic                    in_resp_valid_o,
    input  logic                    in_resp_ready_i,
    output logic [IniAddrWidth-1:0] in_resp_ini_addr_o,
    output logic [DataWidth-1:0]    in_resp_rdata_o,

    output logic                    bank_req_o,
    output logic                    bank_we_o,
    output logic [AddrWidth-1:0]    bank_addr_o,
    output logic [DataWidth-1:0]    bank_wdata_o,
    output logic [BeWidth-1:0]      bank_be_o,
    input  logic [DataWidth-1:0]    bank_rdata_i
);

    if (FifoDepth < 1) begin : g_depth_check
        $fatal(1, "tcdm_bank_adapter: FifoDepth must be at least 1");
    end

    localparam int CntW = (FifoDepth < 1) ? 1 : $clog2(FifoDepth + 1);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int MemDepth = (FifoDepth < 1) ? 1 : FifoDepth;

    typedef struct packed {
        logic [IniAddrWidth-1:0] ini;
        logic [DataWidth-1:0]    rdata;
    } resp_t;

    // Registered state
    logic [CntW-1:0]         cnt_q;         // reads accepted and not yet popped
    logic [CntW-1:0]         occ_q;         // entries stored in the FIFO
    logic [PtrW-1:0]         rd_ptr_q;
    logic [PtrW-1:0]         wr_ptr_q;
    logic                    rd_pending_q;  // bank read data arrives this cycle
    logic [IniAddrWidth-1:0] pending_ini_q;
    resp_t                   mem_q [MemDepth];

    // Combinational control
    logic  req_accept;
    logic  rd_accept;
    logic  push_vld;
    resp_t push_dat;
    logic  fifo_empty;
    logic  resp_vld;
    resp_t head_dat;
    logic  pop;
    logic  store;
    logic  drain;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on the credit register: no path from resp_ready or req_valid.
    assign in_req_ready_o = (cnt_q < CntW'(FifoDepth));

    always_comb begin
        req_accept = in_req_valid_i && in_req_ready_o;
        rd_accept  = req_accept && !in_req_wen_i;

        push_vld       = rd_pending_q;
        push_dat.ini   = pending_ini_q;
        push_dat.rdata = bank_rdata_i;

        fifo_empty = (occ_q == '0);
        resp_vld   = !fifo_empty || push_vld;
        // Fall-through: an empty FIFO presents the entry being pushed this cycle.
        head_dat   = fifo_empty ? push_dat : mem_q[rd_ptr_q];

        pop   = resp_vld && in_resp_ready_i;
        // A push that is popped straight through the bypass never touches storage.
        store = push_vld && !(fifo_empty && pop);
        drain = pop && !fifo_empty;
    end

    assign in_resp_valid_o    = resp_vld;
    assign in_resp_ini_addr_o = resp_vld ? head_dat.ini   : '0;
    assign in_resp_rdata_o    = resp_vld ? head_dat.rdata : '0;

    // Bank side: strobe only on accept; the remaining fields simply pass through.
    assign bank_req_o   = req_accept;
    assign bank_we_o    = in_req_wen_i;
    assign bank_addr_o  = in_req_tgt_addr_i;
    assign bank_wdata_o = in_req_wdata_i;
    assign bank_be_o    = in_req_be_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            occ_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_pending_q  <= 1'b0;
            pending_ini_q <= '0;
        end else begin
            rd_pending_q <= rd_accept;
            if (rd_accept) begin
                pending_ini_q <= in_req_ini_addr_i;
            end

            case ({rd_accept, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase

            occ_q <= occ_q + CntW'(store) - CntW'(drain);
            if (store) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (drain) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Credits guarantee a free slot for every push.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_vld && occ_q == CntW'(FifoDepth)));

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
module tb_tcdm_bank_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic [3:0]  req_ini;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_ini;
    logic [31:0] resp_rdata;
    logic        bank_req;
    logic        bank_we;
    logic [9:0]  bank_addr;
    logic [31:0] bank_wdata;
    logic [3:0]  bank_be;
    logic [31:0] bank_rdata;

    bit   [31:0] bank_mem [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcdm_bank_adapter #(
        .AddrWidth(10), .DataWidth(32), .BeWidth(4), .IniAddrWidth(4), .FifoDepth(2)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .in_req_valid_i     (req_valid),
        .in_req_ready_o     (req_ready),
        .in_req_tgt_addr_i  (req_addr),
        .in_req_ini_addr_i  (req_ini),
        .in_req_wen_i       (req_wen),
        .in_req_wdata_i     (req_wdata),
        .in_req_be_i        (req_be),
        .in_resp_valid_o    (resp_valid),
        .in_resp_ready_i    (resp_ready),
        .in_resp_ini_addr_o (resp_ini),
        .in_resp_rdata_o    (resp_rdata),
        .bank_req_o         (bank_req),
        .bank_we_o          (bank_we),
        .bank_addr_o        (bank_addr),
        .bank_wdata_o       (bank_wdata),
        .bank_be_o          (bank_be),
        .bank_rdata_i       (bank_rdata)
    );

    // Single-cycle SRAM bank with byte enables.
    always @(posedge clk) begin
        if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bank_be[b]) bank_mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
                end
            end else begin
                bank_rdata <= bank_mem[bank_addr];
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input logic [9:0] addr, input logic [3:0] ini);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_ini = ini;
        req_wdata = 32'h0; req_be = 4'hF;
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_ini = 4'h0;
        req_wdata = data; req_be = be;
        next_cycle();
        req_valid = 1'b0; req_wen = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_ini = '0;
        req_wdata = '0; req_be = '0; resp_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (bank_req !== 1'b0) begin errors++; $display("FAIL reset_bank_req: got %b expected 0", bank_req); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_ini !== 4'h0) begin errors++; $display("FAIL reset_resp_ini: got %h expected 0", resp_ini); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_read;
        do_write(10'h3, 32'hDEADBEEF, 4'hF);
        resp_ready = 1'b1;
        drive_read(10'h3, 4'd5);
        @(negedge clk);
        checks++; if (bank_req !== 1'b1 || bank_we !== 1'b0 || bank_addr !== 10'h3) begin
            errors++; $display("FAIL single_bank_drive: got req=%b we=%b addr=%h expected 1 0 003", bank_req, bank_we, bank_addr); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", resp_valid); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", resp_rdata); end
        checks++; if (resp_ini !== 4'd5) begin errors++; $display("FAIL single_ini: got %0d expected 5", resp_ini); end
        checks++; if (bank_req !== 1'b0) begin errors++; $display("FAIL single_idle_bank: got %b expected 0", bank_req); end
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop: got %b expected 0", resp_valid); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        for (int i = 0; i < 8; i++) do_write(10'(16 + i), 32'hA5000000 + 32'(i), 4'hF);
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_read(10'(16 + i), 4'(i));
            @(negedge clk);
            if (req_ready === 1'b1) accepts++;
            if (i == 0) begin
                checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid: got %b expected 0", resp_valid); end
            end else begin
                checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5000000 + 32'(i - 1) || resp_ini !== 4'(i - 1)) begin
                    errors++; $display("FAIL b2b_resp%0d: got v=%b d=%h t=%0d expected 1 %h %0d",
                                       i - 1, resp_valid, resp_rdata, resp_ini, 32'hA5000000 + 32'(i - 1), i - 1); end
            end
            next_cycle();
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5000007 || resp_ini !== 4'd7) begin
            errors++; $display("FAIL b2b_resp7: got v=%b d=%h t=%0d expected 1 a5000007 7", resp_valid, resp_rdata, resp_ini); end
        checks++; if (accepts != 8) begin errors++; $display("FAIL b2b_accepts: got %0d expected 8", accepts); end
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", resp_valid); end
        next_cycle();
    endtask

    task automatic test_backpressure;
        do_write(10'd32, 32'h11110020, 4'hF);
        do_write(10'd33, 32'h22220021, 4'hF);
        do_write(10'd34, 32'h33330022, 4'hF);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_read(10'(32 + i), 4'(i + 1));
            @(negedge clk);
            checks++; if (req_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", i, req_ready, i < 2); end
            if (i == 2) begin
                checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11110020 || resp_ini !== 4'd1) begin
                    errors++; $display("FAIL bp_head_held: got v=%b d=%h t=%0d expected 1 11110020 1", resp_valid, resp_rdata, resp_ini); end
            end
            next_cycle();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11110020 || resp_ini !== 4'd1) begin
            errors++; $display("FAIL bp_drain0: got v=%b d=%h t=%0d expected 1 11110020 1", resp_valid, resp_rdata, resp_ini); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_before_pop: got %b expected 0", req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h22220021 || resp_ini !== 4'd2) begin
            errors++; $display("FAIL bp_drain1: got v=%b d=%h t=%0d expected 1 22220021 2", resp_valid, resp_rdata, resp_ini); end
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", resp_valid); end
        next_cycle();
    endtask

    task automatic test_write_read;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'h7; req_ini = 4'h2;
        req_wdata = 32'h12345678; req_be = 4'b0011;
        @(negedge clk);
        checks++; if (bank_req !== 1'b1 || bank_we !== 1'b1 || bank_be !== 4'b0011 || bank_wdata !== 32'h12345678) begin
            errors++; $display("FAIL wr_bank_drive: got req=%b we=%b be=%b d=%h expected 1 1 0011 12345678",
                               bank_req, bank_we, bank_be, bank_wdata); end
        next_cycle();
        drive_read(10'h7, 4'd9);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_response: got %b expected 0", resp_valid); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00005678 || resp_ini !== 4'd9) begin
            errors++; $display("FAIL wr_readback: got v=%b d=%h t=%0d expected 1 00005678 9", resp_valid, resp_rdata, resp_ini); end
        next_cycle();
    endtask

    task automatic test_full_simul;
        do_write(10'd40, 32'h0000AA40, 4'hF);
        do_write(10'd41, 32'h0000BB41, 4'hF);
        do_write(10'd42, 32'h0000CC42, 4'hF);
        resp_ready = 1'b0;
        drive_read(10'd40, 4'd1);
        next_cycle();
        drive_read(10'd41, 4'd2);
        next_cycle();
        resp_ready = 1'b1;
        drive_read(10'd42, 4'd3);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000AA40 || resp_ini !== 4'd1) begin
            errors++; $display("FAIL full_head_a: got v=%b d=%h t=%0d expected 1 0000aa40 1", resp_valid, resp_rdata, resp_ini); end
        next_cycle();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || bank_req !== 1'b1) begin
            errors++; $display("FAIL full_accept_with_pop: got ready=%b bank_req=%b expected 1 1", req_ready, bank_req); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000BB41 || resp_ini !== 4'd2) begin
            errors++; $display("FAIL full_head_b: got v=%b d=%h t=%0d expected 1 0000bb41 2", resp_valid, resp_rdata, resp_ini); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000CC42 || resp_ini !== 4'd3 || req_ready !== 1'b1) begin
            errors++; $display("FAIL full_head_c: got v=%b d=%h t=%0d rdy=%b expected 1 0000cc42 3 1",
                               resp_valid, resp_rdata, resp_ini, req_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", resp_valid); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        resp_ready = 1'b0;
        drive_read(10'd32, 4'd6);
        next_cycle();
        drive_read(10'd33, 4'd7);
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_queued: got v=%b rdy=%b expected 1 0", resp_valid, req_ready); end
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after_reset: got v=%b rdy=%b expected 0 1", resp_valid, req_ready); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            if (resp_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_write_read();
        test_full_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
